scan_test_ctrl: RTL and testbench

Parametrised hardware scan-test sequencer for qtcore-style scan chains. It replaces bench-driven bit-banging of the scan enable, processor enable and scan-in lines. A host streams NUM_CHAINS-bit beats through a valid/ready port. The block drives the chain and the processor-enable line for load / run / unload sequences and returns the captured scan-out stream through a second valid/ready port.

---
 rtl/scan_test_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: streams host beats into the scan chains, pulses processor enable, returns captured scan-out.
// Optional CRC-16-CCITT signature of the final shift pass when SCAN_TEST_CTRL_SIGNATURE_EN is defined.
module scan_test_ctrl #(
  parameter int CHAIN_LEN  = 152,
  parameter int NUM_CHAINS = 1,
  parameter int RUN_W      = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic [1:0]            mode_in,
  input  logic [RUN_W-1:0]      run_cycles_in,
  input  logic                  abort_in,
  input  logic [NUM_CHAINS-1:0] in_data_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  output logic [NUM_CHAINS-1:0] out_data_out,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic                  scan_en_out,
  output logic [NUM_CHAINS-1:0] scan_in_out,
  input  logic [NUM_CHAINS-1:0] scan_out_in,
  output logic                  proc_en_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [2:0]            dbg_state_out
`ifdef SCAN_TEST_CTRL_SIGNATURE_EN
  ,output logic [15:0]          signature_out
`endif
);

  localparam int CNT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT_A = 3'd1,
    ST_GAP_A   = 3'd2,
    ST_RUN     = 3'd3,
    ST_GAP_B   = 3'd4,
    ST_SHIFT_B = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [1:0] MODE_RUN = 2'd1;
  localparam logic [1:0] MODE_SRS = 2'd2;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [RUN_W-1:0]      run_cycles_q, run_cycles_d;
  logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [NUM_CHAINS-1:0] out_data_q, out_data_d;

  logic shift_state;
  logic in_ready;
  logic fire;
  logic last_beat;
  logic start_ok;

  // Handshake: a beat transfers on in_valid_in & in_ready_out; a captured beat
  // transfers on out_valid_out & out_ready_in. The chain only shifts on a transfer.
  always_comb begin
    shift_state = (state_q == ST_SHIFT_A) || (state_q == ST_SHIFT_B);
    in_ready    = shift_state && (!out_valid_q || out_ready_in);
    fire        = in_valid_in && in_ready && !abort_in;
    last_beat   = (beat_cnt_q == CNT_W'(CHAIN_LEN - 1));
    start_ok    = (state_q == ST_IDLE) && start_in && !out_valid_q;
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    run_cycles_d = run_cycles_q;
    run_cnt_d    = run_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = scan_out_in;
    end else if (out_ready_in) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mode_d       = mode_in;
          run_cycles_d = run_cycles_in;
          if (mode_in == MODE_RUN) begin
            state_d = (run_cycles_in == '0) ? ST_DONE : ST_RUN;
          end else begin
            state_d = ST_SHIFT_A;
          end
        end
      end
      ST_SHIFT_A: begin
        if (fire) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = (mode_q == MODE_SRS) ? ST_GAP_A : ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP_A: begin
        state_d = (run_cycles_q == '0) ? ST_GAP_B : ST_RUN;
      end
      ST_RUN: begin
        if (run_cnt_q == run_cycles_q - RUN_W'(1)) begin
          run_cnt_d = '0;
          state_d   = (mode_q == MODE_SRS) ? ST_GAP_B : ST_DONE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      ST_GAP_B: begin
        state_d = ST_SHIFT_B;
      end
      ST_SHIFT_B: begin
        if (fire) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a beat presented this cycle.
    if (abort_in && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      run_cnt_d   = '0;
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      run_cycles_q <= '0;
      run_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      run_cycles_q <= run_cycles_d;
      run_cnt_q    <= run_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  always_comb begin
    in_ready_out  = in_ready;
    scan_en_out   = fire;
    scan_in_out   = fire ? in_data_in : '0;
    proc_en_out   = (state_q == ST_RUN) && !abort_in;
    busy_out      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done_out      = (state_q == ST_DONE);
    out_valid_out = out_valid_q;
    out_data_out  = out_data_q;
    dbg_state_out = state_q;
  end

`ifdef SCAN_TEST_CTRL_SIGNATURE_EN
  logic [15:0] crc_q, crc_d;
  logic        final_pass;

  // Chain 0 is folded in first; polynomial x^16+x^12+x^5+1, MSB-first, zero seed.
  function automatic logic [15:0] crc_beat(input logic [15:0] crc_in,
                                           input logic [NUM_CHAINS-1:0] beat);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      fb = c[15] ^ beat[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  always_comb begin
    crc_d      = crc_q;
    final_pass = (state_q == ST_SHIFT_B) ||
                 ((state_q == ST_SHIFT_A) && (mode_q != MODE_SRS));
    if (start_ok) begin
      crc_d = '0;
    end else if (fire && final_pass) begin
      crc_d = crc_beat(crc_q, scan_out_in);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign signature_out = crc_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: behavioural scan-chain/processor model, expected unload queue, directed scenarios.
module tb_scan_test_ctrl;
  localparam int CL = 152;
  localparam int NC = 1;
  localparam int RW = 16;
  localparam int CW = 160;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [RW-1:0] run_cycles_in = '0;
  logic          abort_in = 1'b0;
  logic [NC-1:0] in_data_in = '0;
  logic          in_valid_in = 1'b0;
  logic          in_ready_out;
  logic [NC-1:0] out_data_out;
  logic          out_valid_out;
  logic          out_ready_in = 1'b0;
  logic          scan_en_out;
  logic [NC-1:0] scan_in_out;
  logic [NC-1:0] scan_out_in;
  logic          proc_en_out;
  logic          busy_out;
  logic          done_out;
  logic [2:0]    dbg_state_out;
`ifdef SCAN_TEST_CTRL_SIGNATURE_EN
  logic [15:0]   signature_out;
`endif

  scan_test_ctrl #(.CHAIN_LEN(CL), .NUM_CHAINS(NC), .RUN_W(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in), .mode_in(mode_in),
    .run_cycles_in(run_cycles_in), .abort_in(abort_in), .in_data_in(in_data_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out), .out_data_out(out_data_out),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in), .scan_en_out(scan_en_out),
    .scan_in_out(scan_in_out), .scan_out_in(scan_out_in), .proc_en_out(proc_en_out),
    .busy_out(busy_out), .done_out(done_out), .dbg_state_out(dbg_state_out)
`ifdef SCAN_TEST_CTRL_SIGNATURE_EN
    , .signature_out(signature_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment: the scan chain (tail = MSB) and a toy processor that increments the chain when enabled.
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;
  assign scan_out_in = chain[CL-1];
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (scan_en_out) chain <= {chain[CL-2:0], scan_in_out[0]};
    else if (proc_en_out) chain <= chain + CL'(1);
  end

  // Scoreboard and per-cycle compare process.
  logic [NC-1:0] exp_q[$];
  logic [CL-1:0] unload_vec = '0;
  int scan_cnt = 0, proc_cnt = 0, done_cnt = 0;
  int proc_first = 0, proc_last = 0, done_cyc = 0;
  logic proc_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_en_out && proc_en_out) check("scan_proc_overlap", 1, 0);
      if (scan_en_out) check("scan_in_follow", CW'(scan_in_out), CW'(in_data_in));
      if (done_out) check("done_not_busy", CW'(busy_out), 0);
      if (out_valid_out && out_ready_in) begin
        if (exp_q.size() == 0) check("unexpected_out_beat", 1, 0);
        else check("out_beat", CW'(out_data_out), CW'(exp_q.pop_front()));
        unload_vec <= {unload_vec[CL-2:0], out_data_out[0]};
      end
      if (scan_en_out) scan_cnt <= scan_cnt + 1;
      if (proc_en_out) begin
        proc_cnt  <= proc_cnt + 1;
        proc_last <= cyc;
        if (!proc_prev) proc_first <= cyc;
      end
      proc_prev <= proc_en_out;
      if (done_out) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // Expected unload order: chain tail (MSB) first.
  task automatic push_image(input logic [CL-1:0] img);
    for (int i = CL - 1; i >= 0; i--) exp_q.push_back(NC'(img[i]));
  endtask

  function automatic logic [15:0] crc_image(input logic [CL-1:0] img);
    logic [15:0] c = '0;
    logic fb;
    for (int i = CL - 1; i >= 0; i--) begin
      fb = c[15] ^ img[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic preload(input logic [CL-1:0] v);
    @(posedge clk); #1;
    preload_val = v; preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic start_seq(input logic [1:0] m, input logic [RW-1:0] rc);
    @(posedge clk); #1;
    start_in = 1'b1; mode_in = m; run_cycles_in = rc;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  // Streams img into the chain (first beat lands at the tail). Optional stalls and abort.
  task automatic shift_pass(input logic [CL-1:0] img, input int out_stall_at,
                            input int in_stall_at, input int abort_at, output int beats);
    int budget = 0, out_stall = 0, in_stall = 0;
    logic stalled;
    beats = 0;
    while (beats < CL && budget < 3000) begin
      @(posedge clk); #1;
      stalled = 1'b0;
      in_data_in = NC'(img[CL-1-beats]);
      if (beats == abort_at) begin
        abort_in = 1'b1; in_valid_in = 1'b1; out_ready_in = 1'b1;
        @(negedge clk);
        check("abort_no_shift", CW'(scan_en_out), 0);
        check("abort_no_proc", CW'(proc_en_out), 0);
        @(posedge clk); #1;
        abort_in = 1'b0; in_valid_in = 1'b0;
        return;
      end
      if (beats == out_stall_at && out_stall < 5) begin
        out_ready_in = 1'b0; out_stall++; stalled = 1'b1;
      end else out_ready_in = 1'b1;
      if (beats == in_stall_at && in_stall < 3) begin
        in_valid_in = 1'b0; in_stall++; stalled = 1'b1;
      end else in_valid_in = 1'b1;
      @(negedge clk);
      if (stalled) check("stall_scan_en", CW'(scan_en_out), 0);
      if (in_valid_in && in_ready_out) beats++;
      budget++;
    end
    if (beats < CL) check("shift_pass_timeout", CW'(beats), CW'(CL));
    @(posedge clk); #1;
    in_valid_in = 1'b0; out_ready_in = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done_out && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!done_out) check("done_timeout", 0, 1);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    check("queue_empty", CW'(exp_q.size()), 0);
  endtask

  int beats, s0, p0, d0;
  logic [CL-1:0] img;

  initial begin
    // Reset with random inputs: every output must stay 0.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start_in = 1'($urandom_range(0, 1)); mode_in = 2'($urandom_range(0, 3));
      run_cycles_in = RW'($urandom_range(0, 65535)); abort_in = 1'($urandom_range(0, 1));
      in_data_in = NC'($urandom_range(0, 1)); in_valid_in = 1'($urandom_range(0, 1));
      out_ready_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_outputs", CW'({in_ready_out, out_data_out, out_valid_out, scan_en_out,
                               scan_in_out, proc_en_out, busy_out, done_out}), 0);
    end
    @(posedge clk); #1;
    start_in = 0; abort_in = 0; in_valid_in = 0; in_data_in = 0; out_ready_in = 1; mode_in = 0;
    run_cycles_in = 0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_not_busy", CW'(busy_out), 0);

    // Scenario 2: SHIFT, unload 0xA5 image, load 0x3C.
    preload({19{8'hA5}});
    push_image({19{8'hA5}});
    s0 = scan_cnt;
    start_seq(2'd0, '0);
    @(negedge clk);
    check("busy_after_start", CW'(busy_out), 1);
    shift_pass({19{8'h3C}}, -1, -1, -1, beats);
    @(negedge clk);
    check("shift_done_pulse", CW'(done_out), 1);
    drain();
    check("shift_chain_3c", CW'(chain), CW'({19{8'h3C}}));
    check("shift_unload_a5", CW'(unload_vec), CW'({19{8'hA5}}));
    check("shift_scan_cycles", CW'(scan_cnt - s0), CW'(CL));
`ifdef SCAN_TEST_CTRL_SIGNATURE_EN
    check("signature_a5", CW'(signature_out), CW'(crc_image({19{8'hA5}})));
`endif

    // RUN with 8 cycles, then with 0.
    p0 = proc_cnt;
    start_seq(2'd1, RW'(8));
    wait_done(100);
    @(posedge clk); #1;
    check("run8_count", CW'(proc_cnt - p0), 8);
    check("run8_consecutive", CW'(proc_last - proc_first + 1), 8);
    check("run8_done_after", CW'(done_cyc - proc_last), 1);
    p0 = proc_cnt; d0 = done_cnt;
    start_seq(2'd1, '0);
    wait_done(20);
    @(posedge clk); #1;
    check("run0_no_proc", CW'(proc_cnt - p0), 0);
    check("run0_done", CW'(done_cnt - d0), 1);

    // SHIFT_RUN_SHIFT with the toy processor: second pass must unload load-image + 8.
    preload({19{8'hC3}});
    push_image({19{8'hC3}});
    p0 = proc_cnt;
    img = {{18{8'h5A}}, 8'hF9};
    start_seq(2'd2, RW'(8));
    shift_pass(img, -1, -1, -1, beats);
    push_image(img + CL'(8));
    shift_pass({19{8'h96}}, -1, -1, -1, beats);
    @(negedge clk);
    check("srs_done_pulse", CW'(done_out), 1);
    drain();
    check("srs_proc_cycles", CW'(proc_cnt - p0), 8);
    check("srs_unload_literal", CW'(unload_vec), CW'({{17{8'h5A}}, 8'h5B, 8'h01}));
    check("srs_chain_96", CW'(chain), CW'({19{8'h96}}));

    // Backpressure on both ports.
    preload({19{8'h69}});
    push_image({19{8'h69}});
    s0 = scan_cnt;
    start_seq(2'd0, '0);
    shift_pass({19{8'h3C}}, 60, 100, -1, beats);
    @(negedge clk);
    check("bp_done_pulse", CW'(done_out), 1);
    drain();
    check("bp_unload_69", CW'(unload_vec), CW'({19{8'h69}}));
    check("bp_scan_cycles", CW'(scan_cnt - s0), CW'(CL));
    check("bp_chain_3c", CW'(chain), CW'({19{8'h3C}}));

    // Abort at beat 40, then a clean sequence.
    preload({19{8'hA5}});
    push_image({19{8'hA5}});
    d0 = done_cnt;
    start_seq(2'd0, '0);
    shift_pass({19{8'h3C}}, -1, -1, 40, beats);
    @(negedge clk);
    check("abort_busy", CW'(busy_out), 0);
    check("abort_out_valid", CW'(out_valid_out), 0);
    check("abort_done", CW'(done_out), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("abort_no_done_pulse", CW'(done_cnt - d0), 0);
    preload({19{8'h0F}});
    push_image({19{8'h0F}});
    start_seq(2'd0, '0);
    shift_pass({19{8'hF0}}, -1, -1, -1, beats);
    @(negedge clk);
    check("post_abort_done", CW'(done_out), 1);
    drain();
    check("post_abort_unload", CW'(unload_vec), CW'({19{8'h0F}}));
    check("post_abort_chain", CW'(chain), CW'({19{8'hF0}}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
